onchip_ram_dp_avmm: RTL and testbench
=====================================

// Module: onchip_ram_dp_avmm
// PURPOSE
// Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1, s2), byte enables, pipelined reads.
// Sits on the HPS/FPGA fabric bus; replaces the fixed 64x8192 single-port RAM for FIR coefficient/sample storage.
// Adds readdatavalid/waitrequest handshake, optional zero-clear sweep after reset, freeze write-protect, and collision arbitration.
// PARAMETERS
// DATA_WIDTH      64    word width, multiple of 8
// ADDR_WIDTH      13    word address width; DEPTH = 2**ADDR_WIDTH
// READ_LATENCY    1     1 or 2 cycles from accepted read to readdatavalid (2 = output register)
// CLEAR_ON_RESET  1     1: write zeros to every word after reset; 0: keep INIT_FILE/previous contents
// INIT_FILE       "onchip_ram_dp_avmm.hex"  power-up contents
// PORTS
// clk              in   1             clock, all logic on rising edge
// reset_n          in   1             synchronous, active-low reset
// clken            in   1             global clock enable; 0 stalls all state
// reset_req        in   1             1: treat as clken=0 (protects RAM during reset sequencing)
// freeze           in   1             1: all writes ignored, reads served
// init_done        out  1             1 once clear sweep finished (or immediately when CLEAR_ON_RESET=0)
// sN_address       in   ADDR_WIDTH    word address, N = 1,2
// sN_byteenable    in   DATA_WIDTH/8  byte lane enables for writes
// sN_chipselect    in   1             slave select
// sN_read          in   1             read request
// sN_write         in   1             write request
// sN_writedata     in   DATA_WIDTH    write data
// sN_readdata      out  DATA_WIDTH    read data, valid only when sN_readdatavalid
// sN_readdatavalid out  1             one pulse per accepted read
// sN_waitrequest   out  1             1: request not accepted this cycle
// BEHAVIOUR
// - Reset (reset_n=0 at edge): readdata=0, readdatavalid=0, read pipeline flushed, init_done=0, FSM->CLEAR (or READY if CLEAR_ON_RESET=0).
// - waitrequest = ~reset_n | ~init_done | ~clken | reset_req (combinational, both ports).
// - FSM CLEAR: clr_addr from 0; each enabled cycle writes all-zero, all lanes, via port A; clr_addr++.
//   At clr_addr=DEPTH-1 write then ->READY, init_done=1 next cycle. Sweep = DEPTH enabled cycles. freeze does NOT block clear.
// - Reset mid-sweep restarts at address 0. clken=0/reset_req=1 pauses sweep, no skipped address.
// - READY: accept = chipselect & ~waitrequest. Write accepted: bytes with byteenable=1 updated; others unchanged.
// - read & write both asserted: write wins, no readdatavalid.
// - Read accepted at edge T: readdata+readdatavalid valid after edge T+READ_LATENCY; one read per cycle per port, back-to-back supported.
// - clken=0 or reset_req=1: RAM, pipeline and readdatavalid hold; a pending valid stays high until pipeline advances.
// - Same-port read-during-write impossible (write wins). Mixed-port: s2 reading address s1 writes same cycle returns OLD data (same reversed).
// - Write collision (both ports write same address same cycle): s1 data applied on s1-enabled lanes; s2 applies only lanes s1 does not enable.
// - freeze=1: writes accepted (waitrequest low) but discarded; reads normal.
// - Address has no out-of-range case (DEPTH = 2**ADDR_WIDTH); addresses wrap naturally.
// TESTING
// 1 ADDR_WIDTH=4, CLEAR_ON_RESET=1: release reset -> waitrequest=1 for 16 cycles, init_done=1 at cycle 17; read all -> 0.
// 2 s1 write 0x11223344_55667788 @0x5, then byteenable=8'h0F data 0xAAAA... @0x5 -> s1 read @0x5 = 0x11223344_AAAAAAAA.
// 3 READ_LATENCY=2: s1 reads @1,2,3 back-to-back -> readdatavalid high 3 cycles starting 2 cycles after first accept, data in order.
// 4 s1 write 0xFF.. be=8'hFF and s2 write 0x00.. be=8'hFF @0x7 same cycle -> word=0xFF..; s2 read @0x7 same cycle returns prior value.
// 5 freeze=1, s2 write 0x1234 @0x3 -> waitrequest=0, later read @0x3 returns prior value; clken=0 for 3 cycles mid-read -> valid held, no loss.
// 6 reset_n=0 for 1 cycle at clr_addr=9 -> sweep restarts at 0, init_done rises 16 enabled cycles after release.

Source files
------------

// File: rtl/onchip_ram_dp_avmm.sv
// onchip_ram_dp_avmm: true-dual-port Avalon-MM RAM with byte enables, pipelined reads and post-reset clear sweep
module onchip_ram_dp_avmm #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 13,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = "onchip_ram_dp_avmm.hex"
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    freeze,
  output logic                    init_done,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);
  localparam int BE = DATA_WIDTH / 8;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [0:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [1:0] s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0] s1_p0_q, s1_p0_d, s1_p1_q, s1_p1_d;
  logic [DATA_WIDTH-1:0] s2_p0_q, s2_p0_d, s2_p1_q, s2_p1_d;
  logic en, wait_all, clearing, wr1, wr2, rd1, rd2;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data;
  logic [BE-1:0] a_mask, b_mask;

  always_comb begin
    en = clken & ~reset_req;
    init_done = state_q == ST_READY;
    wait_all = ~reset_n | ~init_done | ~en;
    s1_waitrequest = wait_all;
    s2_waitrequest = wait_all;
    wr1 = s1_chipselect & ~wait_all & s1_write;
    wr2 = s2_chipselect & ~wait_all & s2_write;
    rd1 = s1_chipselect & ~wait_all & s1_read & ~s1_write;
    rd2 = s2_chipselect & ~wait_all & s2_read & ~s2_write;
    // The clear sweep borrows port A and ignores freeze
    clearing = reset_n & en & (state_q == ST_CLEAR);
    a_addr = clearing ? clr_addr_q : s1_address;
    a_data = clearing ? '0 : s1_writedata;
    a_mask = clearing ? '1 : (wr1 & ~freeze ? s1_byteenable : '0);
    b_mask = wr2 & ~freeze ? s2_byteenable : '0;
    state_d = clearing & (&clr_addr_q) ? ST_READY : state_q;
    clr_addr_d = clearing ? clr_addr_q + 1'b1 : clr_addr_q;
    s1_vld_d = en ? {s1_vld_q[0], rd1} : s1_vld_q;
    s2_vld_d = en ? {s2_vld_q[0], rd2} : s2_vld_q;
    s1_p0_d = rd1 ? mem[s1_address] : s1_p0_q;
    s2_p0_d = rd2 ? mem[s2_address] : s2_p0_q;
    s1_p1_d = en ? s1_p0_q : s1_p1_q;
    s2_p1_d = en ? s2_p0_q : s2_p1_q;
    s1_readdata = READ_LATENCY == 2 ? s1_p1_q : s1_p0_q;
    s2_readdata = READ_LATENCY == 2 ? s2_p1_q : s2_p0_q;
    s1_readdatavalid = READ_LATENCY == 2 ? s1_vld_q[1] : s1_vld_q[0];
    s2_readdatavalid = READ_LATENCY == 2 ? s2_vld_q[1] : s2_vld_q[0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
      clr_addr_q <= '0;
      s1_vld_q <= '0;
      s2_vld_q <= '0;
      s1_p0_q <= '0;
      s1_p1_q <= '0;
      s2_p0_q <= '0;
      s2_p1_q <= '0;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_p0_q <= s1_p0_d;
      s1_p1_q <= s1_p1_d;
      s2_p0_q <= s2_p0_d;
      s2_p1_q <= s2_p1_d;
    end
  end

  // Port A is assigned last so it owns its lanes on a same-address collision
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE; i++) begin
      if (b_mask[i]) mem[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
      if (a_mask[i]) mem[a_addr][8*i +: 8] <= a_data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_onchip_ram_dp_avmm.sv
// tb_onchip_ram_dp_avmm: scoreboard bench for the dual-port Avalon-MM RAM (16 words, read latency 2)
module tb_onchip_ram_dp_avmm;
  logic clk = 1'b0;
  logic reset_n, clken, reset_req, freeze, init_done;
  logic [3:0] s1_address, s2_address;
  logic [7:0] s1_byteenable, s2_byteenable;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [63:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic s1_readdatavalid, s1_waitrequest, s2_readdatavalid, s2_waitrequest;

  int checks = 0;
  int failures = 0;
  bit ready = 1'b0;
  bit adv = 1'b0;
  logic [63:0] model [16];
  logic [63:0] q1 [$];
  logic [63:0] q2 [$];
  logic [63:0] exp1, exp2;

  onchip_ram_dp_avmm #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .init_done(init_done),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest)
  );

  always #5 clk = ~clk;

  // Reference model: reads see pre-write contents, s1 lanes beat s2 lanes on collision
  always @(posedge clk) begin
    adv = reset_n && clken && !reset_req;
    if (!reset_n) begin
      q1.delete();
      q2.delete();
    end else if (ready && clken && !reset_req) begin
      if (s1_chipselect && s1_read && !s1_write) q1.push_back(model[s1_address]);
      if (s2_chipselect && s2_read && !s2_write) q2.push_back(model[s2_address]);
      if (!freeze) begin
        for (int i = 0; i < 8; i++)
          if (s2_chipselect && s2_write && s2_byteenable[i]) model[s2_address][8*i +: 8] = s2_writedata[8*i +: 8];
        for (int i = 0; i < 8; i++)
          if (s1_chipselect && s1_write && s1_byteenable[i]) model[s1_address][8*i +: 8] = s1_writedata[8*i +: 8];
      end
    end
  end

  always @(negedge clk) begin
    if (adv && s1_readdatavalid) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL s1_unexpected_valid got=%h", s1_readdata);
      end else begin
        exp1 = q1.pop_front();
        if (s1_readdata !== exp1) begin
          failures++;
          $display("FAIL s1_readdata got=%h exp=%h", s1_readdata, exp1);
        end
      end
    end
    if (adv && s2_readdatavalid) begin
      checks++;
      if (q2.size() == 0) begin
        failures++;
        $display("FAIL s2_unexpected_valid got=%h", s2_readdata);
      end else begin
        exp2 = q2.pop_front();
        if (s2_readdata !== exp2) begin
          failures++;
          $display("FAIL s2_readdata got=%h exp=%h", s2_readdata, exp2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p1(input logic rd, input logic wr, input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    s1_chipselect = rd | wr; s1_read = rd; s1_write = wr; s1_address = a; s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic p2(input logic rd, input logic wr, input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
    s2_chipselect = rd | wr; s2_read = rd; s2_write = wr; s2_address = a; s2_writedata = d; s2_byteenable = be;
  endtask

  task automatic idle();
    p1(0, 0, 4'h0, 64'h0, 8'h0);
    p2(0, 0, 4'h0, 64'h0, 8'h0);
  endtask

  task automatic drain(input string name);
    idle();
    repeat (4) step();
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending s1=%0d s2=%0d exp=0", name, q1.size(), q2.size());
    end
  endtask

  task automatic sweep_and_read_all(input string name);
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (init_done !== (i == 16) || s1_waitrequest !== (i != 16)) begin
        failures++;
        $display("FAIL %s_sweep cycle=%0d init_done=%b wait=%b exp_init=%b", name, i, init_done, s1_waitrequest, i == 16);
      end
    end
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      p1(1, 0, 4'(i), 64'h0, 8'h0);
      p2(1, 0, 4'(15 - i), 64'h0, 8'h0);
      step();
    end
    drain(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0; freeze = 1'b0; ready = 1'b0;
    idle();
    step();
    step();
    checks++;
    if (init_done !== 1'b0 || s1_waitrequest !== 1'b1 || s2_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL reset_status init_done=%b w1=%b w2=%b exp=0,1,1", init_done, s1_waitrequest, s2_waitrequest);
    end
    checks++;
    if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0 || s1_readdata !== 64'h0 || s2_readdata !== 64'h0) begin
      failures++;
      $display("FAIL reset_outputs v1=%b v2=%b d1=%h d2=%h exp=0", s1_readdatavalid, s2_readdatavalid, s1_readdata, s2_readdata);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (s1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_wait got=%b exp=1", s1_waitrequest);
    end
    sweep_and_read_all("reset");
  endtask

  task automatic test_byteenable();
    p1(0, 1, 4'h5, 64'h11223344_55667788, 8'hFF); step();
    p1(0, 1, 4'h5, 64'hAAAAAAAA_AAAAAAAA, 8'h0F); step();
    p1(1, 0, 4'h5, 64'h0, 8'h0); step();
    p1(1, 1, 4'h8, 64'hDEADBEEF_0BADF00D, 8'hFF); step();
    p1(1, 0, 4'h8, 64'h0, 8'h0); step();
    drain("byteenable");
  endtask

  task automatic test_back_to_back();
    p2(0, 1, 4'h1, 64'h01010101_01010101, 8'hFF); step();
    p2(0, 1, 4'h2, 64'h02020202_02020202, 8'hFF); step();
    p2(0, 1, 4'h3, 64'h03030303_03030303, 8'hFF); step();
    p2(0, 1, 4'hC, 64'h77777777_77777777, 8'hFF); step();
    idle(); step();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) p1(1, 0, 4'(i + 1), 64'h0, 8'h0);
      else idle();
      step();
      checks++;
      if (s1_readdatavalid !== (i >= 1 && i <= 3)) begin
        failures++;
        $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", i, s1_readdatavalid, i >= 1 && i <= 3);
      end
    end
    drain("b2b");
  endtask

  task automatic test_collision();
    p1(0, 1, 4'h7, 64'h5A5A5A5A_5A5A5A5A, 8'hFF); step();
    p1(0, 1, 4'h7, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    p2(0, 1, 4'h7, 64'h0, 8'hFF); step();
    p1(0, 1, 4'h7, 64'h01234567_89ABCDEF, 8'hFF);
    p2(1, 0, 4'h7, 64'h0, 8'h0); step();
    p1(0, 0, 4'h0, 64'h0, 8'h0); step();
    p1(0, 1, 4'h7, 64'h11111111_11111111, 8'h0F);
    p2(0, 1, 4'h7, 64'h22222222_22222222, 8'hFF); step();
    idle();
    p2(1, 0, 4'h7, 64'h0, 8'h0); step();
    drain("collision");
  endtask

  task automatic test_freeze_clken();
    p1(0, 1, 4'h3, 64'hCAFEF00D_12345678, 8'hFF); step();
    idle();
    freeze = 1'b1;
    p2(0, 1, 4'h3, 64'h1234, 8'hFF);
    #1;
    checks++;
    if (s2_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL freeze_wait got=%b exp=0", s2_waitrequest);
    end
    step();
    freeze = 1'b0;
    p2(1, 0, 4'h3, 64'h0, 8'h0); step();
    idle();
    reset_req = 1'b1;
    p1(0, 1, 4'h3, 64'hBAD0BAD0_BAD0BAD0, 8'hFF);
    #1;
    checks++;
    if (s1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_wait got=%b exp=1", s1_waitrequest);
    end
    step();
    reset_req = 1'b0;
    p1(1, 0, 4'h3, 64'h0, 8'h0); step();
    p1(1, 0, 4'h1, 64'h0, 8'h0); step();
    idle();
    clken = 1'b0;
    #1;
    checks++;
    if (s1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL clken_wait got=%b exp=1", s1_waitrequest);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (s1_readdatavalid !== 1'b1 || s1_readdata !== 64'hCAFEF00D_12345678) begin
        failures++;
        $display("FAIL clken_hold cycle=%0d v=%b d=%h exp=1 cafef00d12345678", i, s1_readdatavalid, s1_readdata);
      end
    end
    clken = 1'b1;
    step();
    checks++;
    if (s1_readdatavalid !== 1'b1 || s1_readdata !== 64'h01010101_01010101) begin
      failures++;
      $display("FAIL clken_resume v=%b d=%h exp=1 0101010101010101", s1_readdatavalid, s1_readdata);
    end
    step();
    checks++;
    if (s1_readdatavalid !== 1'b0) begin
      failures++;
      $display("FAIL clken_after got=%b exp=0", s1_readdatavalid);
    end
    drain("freeze");
  endtask

  task automatic test_reset_mid_sweep();
    idle();
    reset_n = 1'b0; ready = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (9) step();
    checks++;
    if (init_done !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_partial got=%b exp=0", init_done);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    sweep_and_read_all("midsweep");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 64'h0;
    test_reset();
    test_byteenable();
    test_back_to_back();
    test_collision();
    test_freeze_clken();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
